// File: rtl/prbs8_pkg.sv
// Shared definitions for the PRBS8 (x^8+x^4+x^3+x^2+1) checker: state encoding,
// tap mask, generator seed and the feedback helper.
package prbs8_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } prbs8_state_e;

  localparam logic [7:0] PRBS8_TAPS = 8'b1000_1110;
  localparam logic [7:0] PRBS8_SEED = 8'hFF;

  // r[n] = r[n-8]^r[n-4]^r[n-3]^r[n-2] with loc[0] holding the newest bit
  function automatic logic prbs8_fb(input logic [7:0] r);
    return ^(r & PRBS8_TAPS);
  endfunction

endpackage

// File: rtl/prbs8_lfsr.sv
// 8-bit PRBS8 shift register: shifts in an external bit (load_bit) or its own
// feedback (run); exposes the predicted next bit and the next register value.
module prbs8_lfsr
  import prbs8_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = PRBS8_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_bit,
  input  logic       run,
  input  logic       in_bit,
  output logic       exp,
  output logic [7:0] loc_next
);

  logic [7:0] loc_q, loc_d;

  always_comb begin
    loc_d = loc_q;
    if (load_bit) begin
      loc_d = {loc_q[6:0], in_bit};
    end else if (run) begin
      loc_d = {loc_q[6:0], prbs8_fb(loc_q)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_q <= RESET_VAL;
    end else begin
      loc_q <= loc_d;
    end
  end

  assign exp      = prbs8_fb(loc_q);
  assign loc_next = loc_d;

endmodule

// File: rtl/prbs8_checker.sv
// Bit-serial PRBS8 checker: self-seeds from the stream (HUNT), confirms
// VERIFY_LEN predicted bits (VERIFY), then counts errors in LOCK.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int unsigned VERIFY_LEN = 16,
  parameter int unsigned LOSS_THR   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic             in_data,
  input  logic             clr_cnt,
  output logic             lock,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      bit_cnt,
  output logic [1:0]       state
);

  localparam int unsigned MW = $clog2(VERIFY_LEN + 1);
  localparam int unsigned LW = $clog2(LOSS_THR + 1);

  prbs8_state_e     state_q, state_d;
  logic [3:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      bit_cnt_q, bit_cnt_d;
  logic             lock_q, lock_d;
  logic             err_flag_q, err_flag_d;

  logic             lfsr_load, lfsr_run, lfsr_exp, hit;
  logic [7:0]       lfsr_next;

  assign lfsr_load = in_en && (state_q == ST_HUNT);
  assign lfsr_run  = in_en && ((state_q == ST_VERIFY) || (state_q == ST_LOCK));
  assign hit       = (in_data == lfsr_exp);

  prbs8_lfsr #(
    .RESET_VAL('0)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst),
    .load_bit (lfsr_load),
    .run      (lfsr_run),
    .in_bit   (in_data),
    .exp      (lfsr_exp),
    .loc_next (lfsr_next)
  );

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    err_flag_d = 1'b0;

    case (state_q)
      ST_HUNT: if (in_en) begin
        if (fill_q == 4'd7) begin
          // an all-zero seed would lock the LFSR up, so refill instead
          fill_d = '0;
          if (lfsr_next != '0) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end else begin
          fill_d = fill_q + 4'd1;
        end
      end
      ST_VERIFY: if (in_en) begin
        if (!hit) begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end else if (match_q == MW'(VERIFY_LEN - 1)) begin
          state_d = ST_LOCK;
          miss_d  = '0;
        end else begin
          match_d = match_q + MW'(1);
        end
      end
      ST_LOCK: if (in_en) begin
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
        if (hit) begin
          miss_d = '0;
        end else begin
          err_flag_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (miss_q == LW'(LOSS_THR - 1)) begin
            state_d = ST_HUNT;
            fill_d  = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + LW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        fill_d  = '0;
      end
    endcase

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      fill_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      lock_q     <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      lock_q     <= lock_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign lock     = lock_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign state    = state_q;

endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Bit-serial PRBS checker that consumes the descrambler output and verifies it against the x^8+x^4+x^3+x^2+1 test sequence. It self-seeds from the received stream, acquires lock, and then counts bit errors against a free-running local reference. It sits directly downstream of `serial_descrambler` on the divided bit clock, or on the fast clock gated by `in_en`. It provides the pass/fail and BER evidence for the scrambler/descrambler loop.

## Interface
Parameters:
- `VERIFY_LEN`, 16: consecutive correct bits needed in VERIFY before LOCK.
- `LOSS_THR`, 4: consecutive mismatches in LOCK that force a return to HUNT.
- `CNT_W`, 16: width of `err_cnt`.

Ports:
- `clk`  in  1: bit clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_en`  in  1: bit strobe; `in_data` is sampled only when 1.
- `in_data`  in  1: descrambled serial bit.
- `clr_cnt`  in  1: synchronous clear of `err_cnt` and `bit_cnt`.
- `lock`  out  1: 1 while in LOCK.
- `err_flag`  out  1: one-cycle pulse for each mismatched bit in LOCK.
- `err_cnt`  out  CNT_W: saturating count of errors in LOCK.
- `bit_cnt`  out  32: saturating count of bits compared in LOCK.
- `state`  out  2: current FSM state, for debug or ILA.

## Operation
- Local 8-bit register `loc`.
- Expected bit: `exp = loc[7]^loc[3]^loc[2]^loc[1]`. These are the same taps as the generator, because r[n] = r[n-8]^r[n-4]^r[n-3]^r[n-2].
- All actions below occur only on cycles with `in_en=1`. When `in_en=0`, all state holds and `err_flag=0`.
- **HUNT (0):**
  - Each bit: `loc <= {loc[6:0], in_data}`; fill counter increments.
  - After 8 bits, go to VERIFY if `loc` is nonzero.
  - An all-zero seed is the LFSR lock-up state: clear the fill counter and stay in HUNT.
- **VERIFY (1):**
  - Each bit: compare `in_data` with `exp`, then `loc <= {loc[6:0], exp}`.
  - The register free-runs; it does not reload from input.
  - A mismatch sends the FSM to HUNT with the fill counter cleared.
  - The VERIFY_LEN-th consecutive match sends the FSM to LOCK.
- **LOCK (2):**
  - Each bit: `loc` free-runs as in VERIFY; `bit_cnt` increments.
  - On a mismatch: `err_flag` pulses, `err_cnt` increments, and the consecutive-miss counter increments.
  - On a match: the consecutive-miss counter clears.
  - When the miss counter reaches LOSS_THR, go to HUNT. The erroring bit of that cycle is still counted.
- Encoding 3 is illegal and recovers to HUNT.
- Counters saturate at all-ones and never wrap.
- `clr_cnt` has priority over an increment in the same cycle: the result is 0. The FSM and `loc` are unaffected.
- Counters hold their values through loss of lock. Only `clr_cnt` or reset clears them.

## Timing
- Reset values:
  - state=HUNT, `loc`=0, all internal counters 0.
  - `lock`=0, `err_flag`=0, `err_cnt`=0, `bit_cnt`=0.
  - Reset acts immediately, mid-stream included.
- All outputs are registered. Each takes effect the cycle after the deciding `in_en` sample.
- From reset with a clean stream, `lock` rises one cycle after the (8+VERIFY_LEN)-th strobed bit (the 24th by default).
- `err_flag` is high for exactly one cycle per erroring bit. `err_cnt` updates on the same edge.
- On loss of lock, `lock` falls the cycle after the LOSS_THR-th consecutive error.

## Structure
- Package `prbs8_pkg`:
  - State encoding constants `ST_HUNT`=0, `ST_VERIFY`=1, `ST_LOCK`=2.
  - Tap mask `PRBS8_TAPS`=8'b1000_1110 over `loc[7:0]`.
  - Seed constant 8'hFF.
- Sub-module `prbs8_lfsr`:
  - Holds the 8-bit register with `load_bit` mode (shift in external bit) and `run` mode (shift in feedback).
  - Outputs `exp`.
  - Reusable by the generator in the top level.

## Test plan
- **Clean acquisition:** reset, then drive the generator stream from seed FFh with `in_en` continuous. Required: `lock` rises after the 24th bit and `err_cnt`=0 after 1000 bits.
- **Single-error injection:** after lock, invert bit 100. Required: one `err_flag` pulse, `err_cnt`=1, `lock` stays 1, `bit_cnt` keeps incrementing.
- **Burst loss:** after lock, invert 4 consecutive bits. Required: `err_cnt`=4 and `lock` falls after the 4th; with the clean stream resumed, `lock` returns 24 bits later and `err_cnt` is still 4.
- **All-zero input:** 64 bits of zero. Required: state stays HUNT, `lock`=0, `err_cnt`=0.
- **Saturation and clear:** with CNT_W=4, inject 20 isolated errors. Required: `err_cnt`=15 held. Then assert `clr_cnt` on a cycle that also has an error. Required: `err_cnt`=0 on the next cycle.
- **Gated strobe and reset mid-LOCK:** drive `in_en` at a 1-in-40 duty. Required: lock after the 24th strobe, with the 39 idle cycles showing no change. Then assert `rst` mid-LOCK. Required: all outputs go to 0 immediately.
